regfile_port_arbiter: RTL and testbench

- Shares the single register file (32 x 32, two combinational read ports A1/A2 -> RD1/RD2, one write port A3/WD3 committed on the rising clk edge when rw=1) between two requesters.
- Each request is either one write or one dual-register read.
- The block arbitrates round-robin, drives the register file address/data/rw pins, and returns read data plus a completion pulse to the winning requester.
- It sits between the control/execution clients and the register file.

---
 rtl/regfile_port_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Two-client round-robin arbiter in front of a 32 x 32 register file.
// Each granted request issues one write or one dual read for exactly one
// cycle, then the winner gets a done pulse and, for reads, the captured data.
module regfile_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_ra1,
  input  logic [AW-1:0] c0_ra2,
  input  logic [AW-1:0] c0_wa,
  input  logic [DW-1:0] c0_wd,
  output logic          c0_gnt,
  output logic          c0_done,
  output logic [DW-1:0] c0_rd1,
  output logic [DW-1:0] c0_rd2,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_ra1,
  input  logic [AW-1:0] c1_ra2,
  input  logic [AW-1:0] c1_wa,
  input  logic [DW-1:0] c1_wd,
  output logic          c1_gnt,
  output logic          c1_done,
  output logic [DW-1:0] c1_rd1,
  output logic [DW-1:0] c1_rd2,
  output logic [AW-1:0] rf_a1,
  output logic [AW-1:0] rf_a2,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd3,
  output logic          rf_rw,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state;
  logic   last_win;
  logic   owner;
  logic   pick1;

  // Client 1 wins when it is the only requester, or when both request and
  // client 0 was the last winner. Resetting last_win to 1 favours client 0.
  always_comb begin
    pick1 = c1_req && (!c0_req || !last_win);
  end

  // Arbitration FSM; every output is a flop so rf_rw clears at once on reset,
  // which also drops an in-flight transaction without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_win <= 1'b1;
      owner    <= 1'b0;
      c0_gnt   <= 1'b0;
      c1_gnt   <= 1'b0;
      c0_done  <= 1'b0;
      c1_done  <= 1'b0;
      c0_rd1   <= '0;
      c0_rd2   <= '0;
      c1_rd1   <= '0;
      c1_rd2   <= '0;
      rf_a1    <= '0;
      rf_a2    <= '0;
      rf_a3    <= '0;
      rf_wd3   <= '0;
      rf_rw    <= 1'b0;
    end else begin
      c0_gnt  <= 1'b0;
      c1_gnt  <= 1'b0;
      c0_done <= 1'b0;
      c1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            state    <= ISSUE;
            owner    <= pick1;
            last_win <= pick1;
            if (pick1) begin
              c1_gnt <= 1'b1;
              rf_a1  <= c1_ra1;
              rf_a2  <= c1_ra2;
              rf_a3  <= c1_wa;
              rf_wd3 <= c1_wd;
              rf_rw  <= c1_we;
            end else begin
              c0_gnt <= 1'b1;
              rf_a1  <= c0_ra1;
              rf_a2  <= c0_ra2;
              rf_a3  <= c0_wa;
              rf_wd3 <= c0_wd;
              rf_rw  <= c0_we;
            end
          end
        end
        ISSUE: begin
          state <= IDLE;
          rf_rw <= 1'b0;
          if (owner) begin
            c1_done <= 1'b1;
            if (!rf_rw) begin
              c1_rd1 <= rf_rd1;
              c1_rd2 <= rf_rd2;
            end
          end else begin
            c0_done <= 1'b1;
            if (!rf_rw) begin
              c0_rd1 <= rf_rd1;
              c0_rd2 <= rf_rd2;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register file
// attached to the rf_* pins.
module tb_regfile_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c0_req = 1'b0, c0_we = 1'b0;
  logic [AW-1:0] c0_ra1 = '0, c0_ra2 = '0, c0_wa = '0;
  logic [DW-1:0] c0_wd = '0;
  logic          c0_gnt, c0_done;
  logic [DW-1:0] c0_rd1, c0_rd2;
  logic          c1_req = 1'b0, c1_we = 1'b0;
  logic [AW-1:0] c1_ra1 = '0, c1_ra2 = '0, c1_wa = '0;
  logic [DW-1:0] c1_wd = '0;
  logic          c1_gnt, c1_done;
  logic [DW-1:0] c1_rd1, c1_rd2;
  logic [AW-1:0] rf_a1, rf_a2, rf_a3;
  logic [DW-1:0] rf_wd3;
  logic          rf_rw;
  logic [DW-1:0] rf_rd1, rf_rd2;

  logic [DW-1:0] mem [32] = '{default: '0};

  int vectors = 0;
  int miscompares = 0;

  regfile_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_ra1(c0_ra1), .c0_ra2(c0_ra2),
    .c0_wa(c0_wa), .c0_wd(c0_wd), .c0_gnt(c0_gnt), .c0_done(c0_done),
    .c0_rd1(c0_rd1), .c0_rd2(c0_rd2),
    .c1_req(c1_req), .c1_we(c1_we), .c1_ra1(c1_ra1), .c1_ra2(c1_ra2),
    .c1_wa(c1_wa), .c1_wd(c1_wd), .c1_gnt(c1_gnt), .c1_done(c1_done),
    .c1_rd1(c1_rd1), .c1_rd2(c1_rd2),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .rf_rw(rf_rw), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Register file model: combinational reads, write on the rising edge.
  always @(posedge clk) begin
    if (rf_rw) mem[rf_a3] <= rf_wd3;
  end
  assign rf_rd1 = mem[rf_a1];
  assign rf_rd2 = mem[rf_a2];

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " c0_gnt"}, {31'b0, c0_gnt}, 0);
    checkOutput({tag, " c1_gnt"}, {31'b0, c1_gnt}, 0);
    checkOutput({tag, " c0_done"}, {31'b0, c0_done}, 0);
    checkOutput({tag, " c1_done"}, {31'b0, c1_done}, 0);
    checkOutput({tag, " rf_rw"}, {31'b0, rf_rw}, 0);
    checkOutput({tag, " rf_a1"}, {27'b0, rf_a1}, 0);
    checkOutput({tag, " rf_a3"}, {27'b0, rf_a3}, 0);
    checkOutput({tag, " rf_wd3"}, rf_wd3, 0);
    checkOutput({tag, " c0_rd1"}, c0_rd1, 0);
    checkOutput({tag, " c1_rd1"}, c1_rd1, 0);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkIdleOutputs("por");

    // Client 0 writes r5 then reads it back
    c0_req = 1; c0_we = 1; c0_wa = 5; c0_wd = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("wr gnt", {31'b0, c0_gnt}, 1);
    checkOutput("wr c1_gnt", {31'b0, c1_gnt}, 0);
    checkOutput("wr rf_rw", {31'b0, rf_rw}, 1);
    checkOutput("wr rf_a3", {27'b0, rf_a3}, 5);
    checkOutput("wr rf_wd3", rf_wd3, 32'hDEADBEEF);
    c0_req = 0;
    applyStimulus();
    checkOutput("wr done", {31'b0, c0_done}, 1);
    checkOutput("wr gnt off", {31'b0, c0_gnt}, 0);
    checkOutput("wr rw off", {31'b0, rf_rw}, 0);
    checkOutput("wr mem5", mem[5], 32'hDEADBEEF);
    c0_req = 1; c0_we = 0; c0_ra1 = 5; c0_ra2 = 0;
    applyStimulus();
    checkOutput("rd gnt", {31'b0, c0_gnt}, 1);
    checkOutput("rd rf_rw", {31'b0, rf_rw}, 0);
    checkOutput("rd rf_a1", {27'b0, rf_a1}, 5);
    checkOutput("rd done early", {31'b0, c0_done}, 0);
    c0_req = 0;
    applyStimulus();
    checkOutput("rd done", {31'b0, c0_done}, 1);
    checkOutput("rd c0_rd1", c0_rd1, 32'hDEADBEEF);
    checkOutput("rd c0_rd2", c0_rd2, 0);
    checkOutput("rd rf_a3 hold", {27'b0, rf_a3}, 5);
    applyStimulus();
    checkOutput("rd1 hold", c0_rd1, 32'hDEADBEEF);

    // Mid-simulation reset with both clients idle clears outputs at once
    #2 rst = 1'b1;
    #1;
    checkIdleOutputs("midrst");
    rst = 1'b0;
    applyStimulus();

    // Both clients hold write requests: grants alternate starting with c0
    c0_req = 1; c0_we = 1; c0_wa = 1; c0_wd = 1;
    c1_req = 1; c1_we = 1; c1_wa = 2; c1_wd = 2;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("rr%0d c0_gnt", i), {31'b0, c0_gnt}, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr%0d c1_gnt", i), {31'b0, c1_gnt}, (i % 2 == 1) ? 1 : 0);
      if (i == 3) begin
        c0_req = 0;
        c1_req = 0;
      end
      applyStimulus();
      checkOutput($sformatf("rr%0d c0_done", i), {31'b0, c0_done}, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr%0d c1_done", i), {31'b0, c1_done}, (i % 2 == 1) ? 1 : 0);
      checkOutput($sformatf("rr%0d gnt gap", i), {30'b0, c0_gnt, c1_gnt}, 0);
    end
    checkOutput("rr mem1", mem[1], 1);
    checkOutput("rr mem2", mem[2], 2);

    // Client 1 alone holds read requests for r1/r2
    c1_req = 1; c1_we = 0; c1_ra1 = 1; c1_ra2 = 2;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput($sformatf("c1rd%0d gnt", i), {31'b0, c1_gnt}, 1);
      checkOutput($sformatf("c1rd%0d done early", i), {31'b0, c1_done}, 0);
      if (i == 1) c1_req = 0;
      applyStimulus();
      checkOutput($sformatf("c1rd%0d gnt off", i), {31'b0, c1_gnt}, 0);
      checkOutput($sformatf("c1rd%0d done", i), {31'b0, c1_done}, 1);
      checkOutput($sformatf("c1rd%0d rd1", i), c1_rd1, 1);
      checkOutput($sformatf("c1rd%0d rd2", i), c1_rd2, 2);
    end

    // Client 0 write of r7 aborted by reset during the issue cycle
    c0_req = 1; c0_we = 1; c0_wa = 7; c0_wd = 32'h12345678;
    applyStimulus();
    checkOutput("abort gnt", {31'b0, c0_gnt}, 1);
    checkOutput("abort rw", {31'b0, rf_rw}, 1);
    c0_req = 0;
    #2 rst = 1'b1;
    #1;
    checkOutput("abort rw async", {31'b0, rf_rw}, 0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("abort no done", {31'b0, c0_done}, 0);
    checkOutput("abort mem7", mem[7], 0);
    c0_req = 1; c0_we = 0; c0_ra1 = 7; c0_ra2 = 5;
    applyStimulus();
    checkOutput("r7 gnt", {31'b0, c0_gnt}, 1);
    c0_req = 0;
    applyStimulus();
    checkOutput("r7 done", {31'b0, c0_done}, 1);
    checkOutput("r7 rd1", c0_rd1, 0);
    checkOutput("r7 rd2", c0_rd2, 32'hDEADBEEF);

    // Client 1 read of r3 issued right after client 0 writes r3
    c0_req = 1; c0_we = 1; c0_wa = 3; c0_wd = 32'hA5A5A5A5;
    applyStimulus();
    checkOutput("wr3 gnt", {31'b0, c0_gnt}, 1);
    c0_req = 0;
    c1_req = 1; c1_we = 0; c1_ra1 = 3; c1_ra2 = 1;
    applyStimulus();
    checkOutput("wr3 done", {31'b0, c0_done}, 1);
    checkOutput("wr3 no c1_gnt", {31'b0, c1_gnt}, 0);
    applyStimulus();
    checkOutput("rd3 gnt", {31'b0, c1_gnt}, 1);
    checkOutput("rd3 c0_gnt", {31'b0, c0_gnt}, 0);
    c1_req = 0;
    applyStimulus();
    checkOutput("rd3 done", {31'b0, c1_done}, 1);
    checkOutput("rd3 rd1", c1_rd1, 32'hA5A5A5A5);
    checkOutput("rd3 rd2", c1_rd2, 1);
    checkOutput("rd3 c0_rd1 hold", c0_rd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
